oven_timer: RTL and testbench

OVEN_TIMER -- requirements
Module: oven_timer

---
 rtl/oven_pkg.sv | 56 +++++
 rtl/oven_timer_if.sv | 25 ++
 rtl/oven_tick_gen.sv | 38 +++
 rtl/oven_timer.sv | 120 ++++++++++++
 tb/tb_oven_timer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oven_pkg.sv
// Shared types and constants for the oven timer: state encoding, time width,
// button priority order and saturating time arithmetic.
package oven_pkg;

    localparam int unsigned TIME_W          = 13;
    localparam int unsigned MAX_SECONDS_DEF = 3599;
    localparam int unsigned ADD_MIN_SEC     = 60;
    localparam int unsigned ADD_10S_SEC     = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // The winning action of a cycle; encoding order is the priority order.
    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,
        ACT_ADD_10S = 3'd1,
        ACT_ADD_MIN = 3'd2,
        ACT_START   = 3'd3,
        ACT_STOP    = 3'd4,
        ACT_CLEAR   = 3'd5
    } action_e;

    function automatic action_e resolve_action(
        input logic clear,
        input logic stop_or_door,
        input logic start,
        input logic add_min,
        input logic add_10s
    );
        if (clear)        return ACT_CLEAR;
        if (stop_or_door) return ACT_STOP;
        if (start)        return ACT_START;
        if (add_min)      return ACT_ADD_MIN;
        if (add_10s)      return ACT_ADD_10S;
        return ACT_NONE;
    endfunction

    // One extra bit of headroom so the sum can never wrap before the clamp.
    function automatic logic [TIME_W-1:0] sat_add(
        input logic [TIME_W-1:0] t,
        input int unsigned       inc,
        input int unsigned       max_s
    );
        logic [TIME_W:0] sum;
        logic [TIME_W:0] lim;
        sum = {1'b0, t} + (TIME_W+1)'(inc);
        lim = (TIME_W+1)'(max_s);
        return (sum > lim) ? lim[TIME_W-1:0] : sum[TIME_W-1:0];
    endfunction

endpackage

// File: rtl/oven_timer_if.sv
// Button/door inputs and display/status outputs of the oven timer.
interface oven_timer_if;

    logic                        btn_add_min;
    logic                        btn_add_10s;
    logic                        btn_start;
    logic                        btn_stop;
    logic                        btn_clear;
    logic                        door_open;
    logic [oven_pkg::TIME_W-1:0] current_time;
    logic                        heating;
    logic                        done;
    logic [2:0]                  state;

    modport master (
        output btn_add_min, btn_add_10s, btn_start, btn_stop, btn_clear, door_open,
        input  current_time, heating, done, state
    );

    modport slave (
        input  btn_add_min, btn_add_10s, btn_start, btn_stop, btn_clear, door_open,
        output current_time, heating, done, state
    );

endinterface

// File: rtl/oven_tick_gen.sv
// One-second tick prescaler: counts while enabled, holds otherwise, and
// restarts from zero on request so every RUN entry gets a full second.
module oven_tick_gen #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable_i,
    input  logic restart_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oven_timer.sv
// Microwave/oven countdown timer: button-driven set/run/pause/done control
// with saturating time entry and a one-second countdown while heating.
module oven_timer
    import oven_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned MAX_SECONDS = MAX_SECONDS_DEF
) (
    input logic         clk,
    input logic         reset_n,
    oven_timer_if.slave bus
);

    localparam int unsigned TIME_MAX = (1 << TIME_W) - 1;
    localparam int unsigned MAX_S    = (MAX_SECONDS > TIME_MAX) ? TIME_MAX : MAX_SECONDS;

    state_e            state_q;
    state_e            state_d;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] time_d;
    logic              heating_q;
    logic              done_q;
    logic              armed_q;
    logic              door_prev_q;
    logic              tick_c;
    logic              restart_c;
    logic              any_btn_c;
    action_e           act_c;

    assign act_c = resolve_action(bus.btn_clear, bus.btn_stop || bus.door_open,
                                  bus.btn_start, bus.btn_add_min, bus.btn_add_10s);

    assign any_btn_c = bus.btn_clear || bus.btn_stop || bus.btn_start ||
                       bus.btn_add_min || bus.btn_add_10s ||
                       (bus.door_open && !door_prev_q);

    // armed_q holds off the first edge after reset release.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (armed_q) begin
            if (act_c == ACT_CLEAR) begin
                state_d = ST_IDLE;
                time_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_SET, ST_PAUSE: begin
                        case (act_c)
                            ACT_START: begin
                                if (time_q != '0) state_d = ST_RUN;
                            end
                            ACT_ADD_MIN: begin
                                time_d = sat_add(time_q, ADD_MIN_SEC, MAX_S);
                                if (state_q == ST_IDLE) state_d = ST_SET;
                            end
                            ACT_ADD_10S: begin
                                time_d = sat_add(time_q, ADD_10S_SEC, MAX_S);
                                if (state_q == ST_IDLE) state_d = ST_SET;
                            end
                            default: begin
                            end
                        endcase
                    end
                    ST_RUN: begin
                        if (act_c == ACT_STOP) begin
                            state_d = ST_PAUSE;
                        end else if (tick_c) begin
                            time_d = time_q - TIME_W'(1);
                            if (time_q == TIME_W'(1)) state_d = ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        time_d = '0;
                        if (any_btn_c) state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        time_d  = '0;
                    end
                endcase
            end
        end
    end

    assign restart_c = (state_d == ST_RUN) && (state_q != ST_RUN);

    oven_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (state_q == ST_RUN),
        .restart_i(restart_c),
        .tick_c   (tick_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            time_q      <= '0;
            heating_q   <= 1'b0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
            door_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            heating_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            armed_q     <= 1'b1;
            door_prev_q <= bus.door_open;
        end
    end

    assign bus.current_time = time_q;
    assign bus.heating      = heating_q;
    assign bus.done         = done_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_oven_timer.sv
// Scoreboard bench for oven_timer: a behavioural oven model predicts every
// cycle's outputs, a monitor compares them against the DUT after each edge.
module tb_oven_timer;

    localparam int unsigned CLK_HZ = 10;
    localparam int          MAXS   = 3599;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_10S   = 5'b00001;
    localparam logic [4:0] B_MIN   = 5'b00010;
    localparam logic [4:0] B_START = 5'b00100;
    localparam logic [4:0] B_STOP  = 5'b01000;
    localparam logic [4:0] B_CLR   = 5'b10000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic door_lvl;

    oven_timer_if bus();

    oven_timer #(
        .CLK_HZ     (CLK_HZ),
        .MAX_SECONDS(MAXS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] tm;
        logic        heat;
        logic        dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural oven: seconds remaining plus cycles spent in the current running second.
    int m_state;
    int m_time;
    int m_phase;
    bit m_armed;
    bit m_door_prev;

    function automatic void model_reset();
        m_state     = S_IDLE;
        m_time      = 0;
        m_phase     = 0;
        m_armed     = 1'b0;
        m_door_prev = 1'b0;
    endfunction

    function automatic void model_step(input logic [4:0] b, input bit door);
        bit clr, stp, sta, am, a10, door_rise;
        int add;
        clr = b[4]; stp = b[3]; sta = b[2]; am = b[1]; a10 = b[0];
        door_rise   = door && !m_door_prev;
        m_door_prev = door;
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        if (clr) begin
            m_state = S_IDLE;
            m_time  = 0;
            return;
        end
        if (m_state == S_DONE) begin
            if (stp || sta || am || a10 || door_rise) m_state = S_IDLE;
            return;
        end
        if (m_state == S_RUN) begin
            if (stp || door) begin
                m_state = S_PAUSE;
                return;
            end
            m_phase++;
            if (m_phase == int'(CLK_HZ)) begin
                m_phase = 0;
                m_time--;
                if (m_time == 0) m_state = S_DONE;
            end
            return;
        end
        if (stp || door) return;
        if (sta) begin
            if (m_time > 0) begin
                m_state = S_RUN;
                m_phase = 0;
            end
            return;
        end
        add = am ? 60 : (a10 ? 10 : 0);
        if (add != 0) begin
            m_time = (m_time + add > MAXS) ? MAXS : m_time + add;
            if (m_state == S_IDLE) m_state = S_SET;
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.st   = 3'(m_state);
        e.tm   = 13'(m_time);
        e.heat = (m_state == S_RUN);
        e.dn   = (m_state == S_DONE);
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp_v);
        n_cmp++;
        if (got != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp_v, $time);
        end
    endtask

    // Called on a falling edge: drive one cycle of inputs, predict, advance.
    task automatic cycle(input logic [4:0] b);
        bus.btn_clear   = b[4];
        bus.btn_stop    = b[3];
        bus.btn_start   = b[2];
        bus.btn_add_min = b[1];
        bus.btn_add_10s = b[0];
        bus.door_open   = door_lvl;
        model_step(b, door_lvl);
        exp_q.push_back(model_exp());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(B_NONE);
    endtask

    // Assert reset between edges and check the outputs fall before the next edge.
    task automatic do_reset_mid();
        bus.btn_clear = 1'b0; bus.btn_stop = 1'b0; bus.btn_start = 1'b0;
        bus.btn_add_min = 1'b0; bus.btn_add_10s = 1'b0;
        door_lvl = 1'b0;
        bus.door_open = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_heating", int'(bus.heating), 0);
        chk("rst_time", int'(bus.current_time), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_state", int'(bus.state), S_IDLE);
        model_reset();
        exp_q.push_back(model_exp());
        @(negedge clk);
        exp_q.push_back(model_exp());
        @(negedge clk);
        reset_n = 1'b1;
        cycle(B_NONE);
    endtask

    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = {bus.state, bus.current_time, bus.heating, bus.done};
                n_cmp++;
                if (g != e) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got st=%0d tm=%0d heat=%0b done=%0b, expected st=%0d tm=%0d heat=%0b done=%0b",
                             $time, g.st, g.tm, g.heat, g.dn, e.st, e.tm, e.heat, e.dn);
                end
            end
        end
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, expected finish before t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] b;
        int         r;
        bus.btn_clear = 1'b0; bus.btn_stop = 1'b0; bus.btn_start = 1'b0;
        bus.btn_add_min = 1'b0; bus.btn_add_10s = 1'b0;
        door_lvl = 1'b0;
        bus.door_open = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_state", int'(bus.state), S_IDLE);
        chk("init_time", int'(bus.current_time), 0);
        chk("init_heating", int'(bus.heating), 0);
        chk("init_done", int'(bus.done), 0);
        reset_n = 1'b1;
        cycle(B_NONE);

        // 2 min + 3 x 10 s, then start: 150 s, first decrement 10 cycles later.
        cycle(B_MIN); cycle(B_MIN);
        cycle(B_10S); cycle(B_10S); cycle(B_10S);
        cycle(B_START);
        chk("run_state", int'(bus.state), S_RUN);
        chk("run_heating", int'(bus.heating), 1);
        chk("run_time", int'(bus.current_time), 150);
        idle(9);
        chk("pre_tick_time", int'(bus.current_time), 150);
        idle(1);
        chk("first_tick_time", int'(bus.current_time), 149);

        // Countdown to completion, then a button dismisses the alarm.
        cycle(B_CLR);
        cycle(B_10S);
        cycle(B_START);
        idle(80);
        chk("two_left", int'(bus.current_time), 2);
        idle(20);
        chk("done_time", int'(bus.current_time), 0);
        chk("done_state", int'(bus.state), S_DONE);
        chk("done_flag", int'(bus.done), 1);
        chk("done_heating", int'(bus.heating), 0);
        cycle(B_STOP);
        chk("dismiss_state", int'(bus.state), S_IDLE);
        chk("dismiss_done", int'(bus.done), 0);

        // Door pause holds time; resume gets a full fresh second.
        cycle(B_MIN);
        cycle(B_10S); cycle(B_10S); cycle(B_10S); cycle(B_10S);
        cycle(B_START);
        idle(3);
        door_lvl = 1'b1;
        idle(7);
        chk("door_state", int'(bus.state), S_PAUSE);
        chk("door_time", int'(bus.current_time), 100);
        chk("door_heating", int'(bus.heating), 0);
        door_lvl = 1'b0;
        cycle(B_START);
        chk("resume_state", int'(bus.state), S_RUN);
        idle(9);
        chk("resume_hold", int'(bus.current_time), 100);
        idle(1);
        chk("resume_tick", int'(bus.current_time), 99);

        // Saturation at the ceiling.
        cycle(B_CLR);
        for (int i = 0; i < 59; i++) cycle(B_MIN);
        for (int i = 0; i < 5; i++) cycle(B_10S);
        chk("time_3590", int'(bus.current_time), 3590);
        cycle(B_MIN);
        chk("sat_min", int'(bus.current_time), MAXS);
        cycle(B_10S);
        chk("sat_10s", int'(bus.current_time), MAXS);

        // Clear beats start; start at zero is ignored.
        cycle(B_CLR);
        cycle(B_MIN);
        chk("set_60", int'(bus.current_time), 60);
        cycle(B_CLR | B_START);
        chk("clr_prio_state", int'(bus.state), S_IDLE);
        chk("clr_prio_time", int'(bus.current_time), 0);
        cycle(B_START);
        chk("start_zero", int'(bus.state), S_IDLE);

        // Reset while heating.
        cycle(B_10S);
        cycle(B_START);
        idle(4);
        chk("pre_rst_heating", int'(bus.heating), 1);
        do_reset_mid();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            b = B_NONE;
            if (r < 5)        b = B_CLR;
            else if (r < 15)  b = B_STOP;
            else if (r < 60)  b = B_START;
            else if (r < 80)  b = B_MIN;
            else if (r < 180) b = B_10S;
            if ($urandom_range(0, 19) == 0) b = b | 5'($urandom_range(0, 31));
            if (door_lvl) begin
                if ($urandom_range(0, 7) == 0) door_lvl = 1'b0;
            end else begin
                if ($urandom_range(0, 59) == 0) door_lvl = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) do_reset_mid();
            else cycle(b);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
